// File: rtl/dromajo_ram_req_port_if.sv
`default_nettype none
// ============================================================================
// Module   : dromajo_ram_req_port_if
// Brief    : Bundle of request, response and RAM strobe signals for the
//            dromajo_ram request front-end. The slave modport is the
//            front-end's view; the master modport is the upstream/RAM view.
// Revision : 1.0 - initial release
// ============================================================================
interface dromajo_ram_req_port_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int RESP_DEPTH = 4
);
    localparam int c_out_w = $clog2(RESP_DEPTH + 1);

    // Upstream request stream
    logic                  ReqValid_SI;
    logic                  ReqReady_SO;
    logic                  ReqWe_SI;
    logic [7:0]            ReqBe_SI;
    logic [ADDR_WIDTH-1:0] ReqAddr_DI;
    logic [63:0]           ReqWData_DI;

    // Read response stream
    logic                  RspValid_SO;
    logic                  RspReady_SI;
    logic [63:0]           RspData_DO;
    logic                  RspErr_SO;

    // RAM strobes
    logic                  CSel_SO;
    logic                  WrEn_SO;
    logic [7:0]            BEn_SO;
    logic [63:0]           WrData_DO;
    logic [ADDR_WIDTH-1:0] Addr_DO;
    logic [63:0]           RdData_DI;

    // Status
    logic [c_out_w-1:0]    Outstanding_SO;

    modport slave (
        input  ReqValid_SI, ReqWe_SI, ReqBe_SI, ReqAddr_DI, ReqWData_DI,
        input  RspReady_SI, RdData_DI,
        output ReqReady_SO, RspValid_SO, RspData_DO, RspErr_SO,
        output CSel_SO, WrEn_SO, BEn_SO, WrData_DO, Addr_DO, Outstanding_SO
    );

    modport master (
        output ReqValid_SI, ReqWe_SI, ReqBe_SI, ReqAddr_DI, ReqWData_DI,
        output RspReady_SI, RdData_DI,
        input  ReqReady_SO, RspValid_SO, RspData_DO, RspErr_SO,
        input  CSel_SO, WrEn_SO, BEn_SO, WrData_DO, Addr_DO, Outstanding_SO
    );
endinterface
`default_nettype wire

// File: rtl/dromajo_ram_req_port.sv
`default_nettype none
// ============================================================================
// Module   : dromajo_ram_req_port
// Brief    : Request front-end for the single-port 64-bit dromajo_ram.
//            Turns a valid/ready request stream into RAM strobes, tracks
//            reads across the RAM latency and returns read data in order on
//            a valid/ready response port. Credits (one per read, held until
//            the response is popped) guarantee the response FIFO never
//            overflows.
//            Optional feature macro: DROMAJO_RAM_REQ_PORT_ERR_EN enables an
//            address range check with error responses for illegal reads.
// Revision : 1.0 - initial release
// ============================================================================
module dromajo_ram_req_port #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_DEPTH = 1024,
    parameter int OUT_REGS   = 0,
    parameter int RESP_DEPTH = 4
) (
    input  logic                  Clk_CI,
    input  logic                  Rst_RBI,
    dromajo_ram_req_port_if.slave bus
);
    localparam int c_lat   = 1 + OUT_REGS;
    localparam int c_cnt_w = $clog2(RESP_DEPTH + 1);
    localparam int c_ptr_w = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
    localparam logic [c_cnt_w-1:0] c_depth    = c_cnt_w'(RESP_DEPTH);
    localparam logic [c_ptr_w-1:0] c_ptr_last = c_ptr_w'(RESP_DEPTH - 1);

    // Elaboration-time sanity checks on the configuration
    generate
        if (RESP_DEPTH < c_lat + 1) begin : g_chk_resp_depth
            $error("RESP_DEPTH must be at least read latency + 1");
        end
        if (DATA_DEPTH > (1 << ADDR_WIDTH)) begin : g_chk_data_depth
            $error("DATA_DEPTH exceeds the ADDR_WIDTH address space");
        end
    endgenerate

    logic                  w_ready;
    logic                  w_accept;
    logic                  w_rd_acc;
    logic                  w_addr_ok;
    logic                  w_csel;
    logic                  w_push;
    logic                  w_rsp_valid;
    logic                  w_pop;
    logic [63:0]           w_push_data;

    logic [c_lat-1:0]      r_pipe_q, r_pipe_d;
    logic [c_cnt_w-1:0]    r_outs_q, r_outs_d;
    logic [c_cnt_w-1:0]    r_fcnt_q, r_fcnt_d;
    logic [c_ptr_w-1:0]    r_wptr_q, r_wptr_d;
    logic [c_ptr_w-1:0]    r_rptr_q, r_rptr_d;
    logic [63:0]           r_mem_q [RESP_DEPTH];

    // Ready depends only on registered credit state (and reset), never on
    // the request itself, so writes also wait for a free credit.
    assign w_ready     = Rst_RBI && (r_outs_q < c_depth);
    assign w_accept    = bus.ReqValid_SI && w_ready;
    assign w_rd_acc    = w_accept && !bus.ReqWe_SI;
    assign w_csel      = w_accept && w_addr_ok;
    assign w_push      = r_pipe_q[c_lat-1];
    assign w_rsp_valid = Rst_RBI && (r_fcnt_q != '0);
    assign w_pop       = w_rsp_valid && bus.RspReady_SI;

`ifdef DROMAJO_RAM_REQ_PORT_ERR_EN
    localparam logic [63:0] c_err_data = 64'hBADC0FFEE0DDF00D;

    logic [c_lat-1:0]      r_epipe_q, r_epipe_d;
    logic [RESP_DEPTH-1:0] r_err_q, r_err_d;

    // Out-of-range addresses never reach the RAM; an illegal read still
    // travels the pipe so its error response keeps request order.
    assign w_addr_ok   = (32'(bus.ReqAddr_DI) < 32'(DATA_DEPTH));
    assign w_push_data = r_epipe_q[c_lat-1] ? c_err_data : bus.RdData_DI;
    assign bus.RspErr_SO = w_rsp_valid && r_err_q[r_rptr_q];

    // Error tag pipe mirrors the read-valid pipe; error flag stored per entry
    always_comb begin
        r_epipe_d    = '0;
        r_epipe_d[0] = w_rd_acc && !w_addr_ok;
        for (int i = 1; i < c_lat; i++) begin
            r_epipe_d[i] = r_epipe_q[i-1];
        end
        r_err_d = r_err_q;
        if (w_push) begin
            r_err_d[r_wptr_q] = r_epipe_q[c_lat-1];
        end
    end

    // Error tag registers
    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI) begin
            r_epipe_q <= '0;
            r_err_q   <= '0;
        end else begin
            r_epipe_q <= r_epipe_d;
            r_err_q   <= r_err_d;
        end
    end
`else
    assign w_addr_ok     = 1'b1;
    assign w_push_data   = bus.RdData_DI;
    assign bus.RspErr_SO = 1'b0;
`endif

    // RAM strobes follow the accepted request in the same cycle
    assign bus.CSel_SO        = w_csel;
    assign bus.WrEn_SO        = w_csel && bus.ReqWe_SI;
    assign bus.BEn_SO         = bus.ReqBe_SI;
    assign bus.Addr_DO        = bus.ReqAddr_DI;
    assign bus.WrData_DO      = bus.ReqWData_DI;

    assign bus.ReqReady_SO    = w_ready;
    assign bus.RspValid_SO    = w_rsp_valid;
    assign bus.RspData_DO     = r_mem_q[r_rptr_q];
    assign bus.Outstanding_SO = Rst_RBI ? r_outs_q : '0;

    // Next-state: read tag pipe, credit counter and FIFO pointers
    always_comb begin
        r_pipe_d    = '0;
        r_pipe_d[0] = w_rd_acc;
        for (int i = 1; i < c_lat; i++) begin
            r_pipe_d[i] = r_pipe_q[i-1];
        end

        r_outs_d = r_outs_q;
        if (w_rd_acc && !w_pop) begin
            r_outs_d = r_outs_q + c_cnt_w'(1);
        end else if (!w_rd_acc && w_pop) begin
            r_outs_d = r_outs_q - c_cnt_w'(1);
        end

        r_fcnt_d = r_fcnt_q;
        if (w_push && !w_pop) begin
            r_fcnt_d = r_fcnt_q + c_cnt_w'(1);
        end else if (!w_push && w_pop) begin
            r_fcnt_d = r_fcnt_q - c_cnt_w'(1);
        end

        r_wptr_d = r_wptr_q;
        if (w_push) begin
            r_wptr_d = (r_wptr_q == c_ptr_last) ? '0 : r_wptr_q + c_ptr_w'(1);
        end

        r_rptr_d = r_rptr_q;
        if (w_pop) begin
            r_rptr_d = (r_rptr_q == c_ptr_last) ? '0 : r_rptr_q + c_ptr_w'(1);
        end
    end

    // Control state registers; reset drops any reads still in the RAM pipe
    always_ff @(posedge Clk_CI) begin
        if (!Rst_RBI) begin
            r_pipe_q <= '0;
            r_outs_q <= '0;
            r_fcnt_q <= '0;
            r_wptr_q <= '0;
            r_rptr_q <= '0;
        end else begin
            r_pipe_q <= r_pipe_d;
            r_outs_q <= r_outs_d;
            r_fcnt_q <= r_fcnt_d;
            r_wptr_q <= r_wptr_d;
            r_rptr_q <= r_rptr_d;
        end
    end

    // Response FIFO storage captures RAM data as each read tag exits the pipe
    always_ff @(posedge Clk_CI) begin
        if (w_push) begin
            r_mem_q[r_wptr_q] <= w_push_data;
        end
    end

    a_fifo_no_overflow: assert property (
        @(posedge Clk_CI) disable iff (!Rst_RBI)
        !(w_push && (r_fcnt_q == c_depth))
    );
endmodule
`default_nettype wire
